// File: rtl/button_event_ctrl.sv
// -----------------------------------------------------------------------------
// button_event_ctrl
//
// Debounces N raw push-button inputs and turns their debounced behaviour into
// a stream of events (press, release, long press) delivered through a small
// 4-entry event FIFO with a valid/ready handshake.
//
// Per channel: 2-flop synchronizer -> M-sample history shifted on every
// sample tick -> debounced level (all-ones sets, all-zeros clears, anything
// else holds).  Level edges and a long-hold counter raise pending-event
// bits.  A round-robin arbiter moves one pending event per clock into the
// FIFO.  An event raised while the same pending bit is still occupied is
// lost and recorded in the sticky ovf flag.
//
// Parameters
//   N          number of button channels (2..8)
//   M          debounce history length in sample ticks (>= 2)
//   TICK_DIV   clock cycles per sample tick (>= 2)
//   LONG_TICKS sample ticks of stable high before a long-press event (>= 1)
//
// Ports
//   clock     in   1  sole clock, all state on the rising edge
//   reset_n   in   1  asynchronous active-low reset
//   btn_in    in   N  raw asynchronous button inputs
//   level     out  N  debounced level per channel
//   ev_valid  out  1  event FIFO not empty
//   ev_ready  in   1  consumer accepts the head event
//   ev_btn    out  3  channel index of the head event
//   ev_type   out  2  head event type: 01 press, 10 release, 11 long press
//   ovf       out  1  sticky event-lost flag
//   clr_ovf   in   1  synchronous clear of ovf (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module button_event_ctrl #(
  parameter int N          = 4,
  parameter int M          = 8,
  parameter int TICK_DIV   = 1000,
  parameter int LONG_TICKS = 200
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] level,
  output logic         ev_valid,
  input  logic         ev_ready,
  output logic [2:0]   ev_btn,
  output logic [1:0]   ev_type,
  output logic         ovf,
  input  logic         clr_ovf
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(N);

  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_TICKS);
  localparam logic [RW-1:0] CH_LAST    = RW'(N - 1);

  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_RELEASE = 2'b10;
  localparam logic [1:0] EV_LONG    = 2'b11;

  // Input synchronizers and sample tick
  logic [N-1:0]  sync1_r;
  logic [N-1:0]  sync2_r;
  logic [PW-1:0] presc_r;
  logic          tick_s;

  // Debounce state
  logic [M-1:0]  hist_r      [N];
  logic [M-1:0]  hist_next_s [N];
  logic [N-1:0]  level_r;
  logic [N-1:0]  level_next_s;
  logic [HW-1:0] hold_r      [N];

  // Event generation and pending bits
  logic [N-1:0]  press_set_s;
  logic [N-1:0]  rel_set_s;
  logic [N-1:0]  long_set_s;
  logic [N-1:0]  pend_press_r;
  logic [N-1:0]  pend_long_r;
  logic [N-1:0]  pend_rel_r;
  logic [N-1:0]  any_pend_s;
  logic          drop_s;
  logic          ovf_r;

  // Arbiter
  logic [RW-1:0] rr_r;
  logic [RW-1:0] rr_next_s;
  logic          found_s;
  logic          gnt_s;
  logic [RW-1:0] gnt_ch_s;
  logic [1:0]    gnt_type_s;
  logic [N-1:0]  clr_press_s;
  logic [N-1:0]  clr_long_s;
  logic [N-1:0]  clr_rel_s;

  // Event FIFO: entry = {channel[2:0], type[1:0]}
  logic [4:0]    fifo_mem_r [4];
  logic [1:0]    wr_ptr_r;
  logic [1:0]    rd_ptr_r;
  logic [2:0]    count_r;
  logic          fifo_full_s;
  logic          pop_s;
  logic          push_s;
  logic [4:0]    head_s;

  // Two-flop synchronizer on every raw button bit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  assign tick_s = (presc_r == TICK_LAST);

  // Prescaler counting 0..TICK_DIV-1; tick_s strobes on the wrap cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + 1'b1;
    end
  end

  // Candidate history and debounced level; both only change on a tick
  always_comb begin
    level_next_s = level_r;
    for (int i = 0; i < N; i++) begin
      hist_next_s[i] = {hist_r[i][M-2:0], sync2_r[i]};
      if (tick_s) begin
        if (&hist_next_s[i]) begin
          level_next_s[i] = 1'b1;
        end else if (~|hist_next_s[i]) begin
          level_next_s[i] = 1'b0;
        end else begin
          level_next_s[i] = level_r[i];
        end
      end else begin
        level_next_s[i] = level_r[i];
      end
    end
  end

  // History shift registers and level register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        hist_r[i] <= '0;
      end
      level_r <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (tick_s) begin
          hist_r[i] <= hist_next_s[i];
        end else begin
          hist_r[i] <= hist_r[i];
        end
      end
      level_r <= level_next_s;
    end
  end

  // Event sources: level edges, and the tick on which the hold count
  // reaches LONG_TICKS (counter saturates there, so this fires once)
  always_comb begin
    press_set_s = ~level_r & level_next_s;
    rel_set_s   = level_r & ~level_next_s;
    long_set_s  = '0;
    for (int i = 0; i < N; i++) begin
      if (level_r[i] && tick_s && (hold_r[i] == HOLD_LAST)) begin
        long_set_s[i] = 1'b1;
      end else begin
        long_set_s[i] = 1'b0;
      end
    end
  end

  // Hold counters: cleared while low, count ticks while high, saturate
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        hold_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!level_r[i]) begin
          hold_r[i] <= '0;
        end else if (tick_s && (hold_r[i] != HOLD_MAX)) begin
          hold_r[i] <= hold_r[i] + 1'b1;
        end else begin
          hold_r[i] <= hold_r[i];
        end
      end
    end
  end

  assign fifo_full_s = (count_r == 3'd4);
  assign pop_s       = (count_r != 3'd0) && ev_ready;

  // Round-robin arbiter: first channel with anything pending, scanning
  // upward from rr_r; within a channel press beats long beats release
  always_comb begin
    any_pend_s  = pend_press_r | pend_long_r | pend_rel_r;
    found_s     = 1'b0;
    gnt_ch_s    = '0;
    gnt_type_s  = EV_PRESS;
    clr_press_s = '0;
    clr_long_s  = '0;
    clr_rel_s   = '0;
    rr_next_s   = rr_r;
    for (int k = 0; k < N; k++) begin
      if (!found_s && any_pend_s[(int'(rr_r) + k) % N]) begin
        found_s  = 1'b1;
        gnt_ch_s = RW'((int'(rr_r) + k) % N);
      end
    end
    if (pend_press_r[gnt_ch_s]) begin
      gnt_type_s = EV_PRESS;
    end else if (pend_long_r[gnt_ch_s]) begin
      gnt_type_s = EV_LONG;
    end else begin
      gnt_type_s = EV_RELEASE;
    end
    // A full FIFO can still take a grant when its head leaves this cycle
    gnt_s = found_s && (!fifo_full_s || pop_s);
    if (gnt_s) begin
      case (gnt_type_s)
        EV_PRESS:   clr_press_s[gnt_ch_s] = 1'b1;
        EV_LONG:    clr_long_s[gnt_ch_s]  = 1'b1;
        EV_RELEASE: clr_rel_s[gnt_ch_s]   = 1'b1;
        default:    clr_press_s           = '0;
      endcase
      rr_next_s = (gnt_ch_s == CH_LAST) ? '0 : gnt_ch_s + 1'b1;
    end else begin
      rr_next_s = rr_r;
    end
  end

  // A set only loses an event if the bit stays occupied after this cycle's
  // grant; a set on the bit being granted simply re-arms it
  assign drop_s = |((press_set_s & pend_press_r & ~clr_press_s) |
                    (long_set_s  & pend_long_r  & ~clr_long_s)  |
                    (rel_set_s   & pend_rel_r   & ~clr_rel_s));

  assign push_s = gnt_s;

  // Pending bits, round-robin pointer and sticky overflow flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_press_r <= '0;
      pend_long_r  <= '0;
      pend_rel_r   <= '0;
      rr_r         <= '0;
      ovf_r        <= 1'b0;
    end else begin
      pend_press_r <= (pend_press_r & ~clr_press_s) | press_set_s;
      pend_long_r  <= (pend_long_r  & ~clr_long_s)  | long_set_s;
      pend_rel_r   <= (pend_rel_r   & ~clr_rel_s)   | rel_set_s;
      rr_r         <= rr_next_s;
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // Event FIFO storage, pointers (wrap mod 4) and occupancy count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < 4; e++) begin
        fifo_mem_r[e] <= 5'd0;
      end
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {3'(gnt_ch_s), gnt_type_s};
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Output view of the FIFO head; fields read as zero while empty
  always_comb begin
    head_s   = fifo_mem_r[rd_ptr_r];
    ev_valid = (count_r != 3'd0);
    if (ev_valid) begin
      ev_btn  = head_s[4:2];
      ev_type = head_s[1:0];
    end else begin
      ev_btn  = 3'd0;
      ev_type = 2'b00;
    end
  end

  assign level = level_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl (N=4, M=4, TICK_DIV=4,
// LONG_TICKS=3).  A behavioural model tracks debounce as run lengths of
// identical samples, pending events as flags and the FIFO as a queue; it is
// compared against the DUT on every falling edge.  Directed sequences add
// explicit checks on event order, latency and the overflow flag.
module tb_button_event_ctrl;
  localparam int N  = 4;
  localparam int M  = 4;
  localparam int TD = 4;
  localparam int L  = 3;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] btn_in  = '0;
  logic [N-1:0] level;
  logic         ev_valid;
  logic         ev_ready = 1'b1;
  logic [2:0]   ev_btn;
  logic [1:0]   ev_type;
  logic         ovf;
  logic         clr_ovf = 1'b0;

  int checks   = 0;
  int failures = 0;

  button_event_ctrl #(.N(N), .M(M), .TICK_DIV(TD), .LONG_TICKS(L)) dut (
    .clock(clock), .reset_n(reset_n), .btn_in(btn_in), .level(level),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_btn(ev_btn),
    .ev_type(ev_type), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int           m_presc;
  logic [N-1:0] m_s1, m_s2;
  int           m_ones  [N];
  int           m_zeros [N];
  int           m_hold  [N];
  bit           m_lvl   [N];
  bit [2:0]     m_pend  [N];   // [0] press, [1] long, [2] release
  int           m_rr;
  int           m_q[$];        // entries ch*4 + type
  bit           m_ovf;
  int           cyc_cnt = 0;

  // observed pops from the DUT
  int obs[$];
  int obs_cyc[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_presc = 0; m_s1 = '0; m_s2 = '0; m_rr = 0; m_ovf = 0;
    m_q.delete();
    for (int c = 0; c < N; c++) begin
      m_ones[c] = 0; m_zeros[c] = M; m_hold[c] = 0; m_lvl[c] = 0; m_pend[c] = 3'b000;
    end
  endtask

  task automatic model_step();
    bit           tk;
    logic [N-1:0] samp;
    bit [2:0]     sets [N];
    bit           nl, pop, drop;
    int           gch, gk, c;
    tk   = (m_presc == TD - 1);
    samp = m_s2;
    m_presc = tk ? 0 : m_presc + 1;
    m_s2 = m_s1;
    m_s1 = btn_in;
    for (int ch = 0; ch < N; ch++) begin
      sets[ch] = 3'b000;
      if (tk) begin
        if (samp[ch]) begin
          m_zeros[ch] = 0; if (m_ones[ch] < M) m_ones[ch]++;
        end else begin
          m_ones[ch] = 0;  if (m_zeros[ch] < M) m_zeros[ch]++;
        end
      end
      nl = (m_ones[ch] >= M) ? 1'b1 : (m_zeros[ch] >= M) ? 1'b0 : m_lvl[ch];
      if (!m_lvl[ch] && nl) sets[ch][0] = 1'b1;
      if (m_lvl[ch] && !nl) sets[ch][2] = 1'b1;
      if (!m_lvl[ch]) m_hold[ch] = 0;
      else if (tk && m_hold[ch] < L) begin
        m_hold[ch]++;
        if (m_hold[ch] == L) sets[ch][1] = 1'b1;
      end
      m_lvl[ch] = nl;
    end
    // one grant per cycle, round robin from m_rr
    pop = (m_q.size() > 0) && ev_ready;
    gch = -1; gk = 0;
    if (m_q.size() < 4 || pop) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (gch < 0 && m_pend[c] != 3'b000) gch = c;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (gch >= 0) begin
      gk = m_pend[gch][0] ? 0 : m_pend[gch][1] ? 1 : 2;
      m_q.push_back(gch * 4 + ((gk == 0) ? 1 : (gk == 1) ? 3 : 2));
      m_pend[gch][gk] = 1'b0;
      m_rr = (gch + 1) % N;
    end
    drop = 0;
    for (int ch = 0; ch < N; ch++)
      for (int k = 0; k < 3; k++)
        if (sets[ch][k]) begin
          if (m_pend[ch][k]) drop = 1;
          m_pend[ch][k] = 1'b1;
        end
    if (drop) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
  endtask

  function automatic logic [N-1:0] m_level_vec();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = m_lvl[c];
    return v;
  endfunction

  function automatic int m_head();
    return (m_q.size() > 0) ? m_q[0] : 0;
  endfunction

  function automatic int obs_at(input int i);
    return (i < obs.size()) ? obs[i] : -1;
  endfunction

  initial model_reset();

  // model advances on the same events as the DUT state
  always @(posedge clock or negedge reset_n) begin
    cyc_cnt++;
    if (!reset_n) model_reset();
    else model_step();
  end

  // compare every cycle on the falling edge, and log accepted events
  always @(negedge clock) begin
    check_val("level", level, m_level_vec());
    check_val("ev_valid", ev_valid, (m_q.size() > 0));
    check_val("head", {ev_btn, ev_type}, m_head());
    check_val("ovf", ovf, m_ovf);
    if (reset_n && ev_valid && ev_ready) begin
      obs.push_back({ev_btn, ev_type});
      obs_cyc.push_back(cyc_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; btn_in = '0; clr_ovf = 1'b0; ev_ready = 1'b1;
    cyc(3);
    reset_n = 1'b1;
    cyc(1);
  endtask

  task automatic wait_obs(input int n, input int limit, input string tag);
    int k = 0;
    while (obs.size() < n && k < limit) begin
      cyc(1);
      k++;
    end
    check_val(tag, (obs.size() >= n), 1'b1);
  endtask

  task automatic clear_obs();
    obs.delete();
    obs_cyc.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int k;
    do_reset();
    check_val("rst_valid", ev_valid, 1'b0);
    check_val("rst_btn", ev_btn, 3'd0);
    check_val("rst_type", ev_type, 2'b00);
    check_val("rst_level", level, 4'h0);
    check_val("rst_ovf", ovf, 1'b0);

    // all four rise together: press round 0..3, long round 0..3, releases
    clear_obs();
    btn_in = 4'hF;
    wait_obs(4, 60, "a_press_timeout");
    for (int i = 0; i < 4; i++) check_val("a_press_order", obs_at(i), i * 4 + 1);
    wait_obs(8, 60, "a_long_timeout");
    for (int i = 0; i < 4; i++) check_val("a_long_order", obs_at(4 + i), i * 4 + 3);
    btn_in = 4'h0;
    wait_obs(12, 60, "a_rel_timeout");
    for (int i = 0; i < 4; i++) check_val("a_rel_order", obs_at(8 + i), i * 4 + 2);
    cyc(40);
    check_val("a_no_extra", obs.size(), 12);

    // single channel press / long / release with timing
    clear_obs();
    btn_in[0] = 1'b1;
    t0 = cyc_cnt;
    wait_obs(1, 40, "b_press_timeout");
    check_val("b_press_ev", obs_at(0), 1);
    if (obs_cyc.size() > 0) check_val("b_press_lat", ((obs_cyc[0] - t0) <= 24), 1'b1);
    check_val("b_level0", level[0], 1'b1);
    wait_obs(2, 40, "b_long_timeout");
    check_val("b_long_ev", obs_at(1), 3);
    if (obs_cyc.size() > 1) check_val("b_long_gap", obs_cyc[1] - obs_cyc[0], 3 * TD);
    cyc(20);
    check_val("b_no_extra", obs.size(), 2);
    btn_in[0] = 1'b0;
    wait_obs(3, 40, "b_rel_timeout");
    check_val("b_rel_ev", obs_at(2), 2);

    // bouncing channel 1: toggles every 5 clocks, never debounces
    clear_obs();
    for (int i = 0; i < 20; i++) begin
      btn_in[1] = ~btn_in[1];
      cyc(5);
      check_val("c_level1", level[1], 1'b0);
    end
    btn_in[1] = 1'b0;
    cyc(30);
    check_val("c_no_events", obs.size(), 0);

    // backpressure: 6 events with ready low, then a repeated pending bit
    do_reset();
    ev_ready = 1'b0;
    btn_in = 4'b0111;
    cyc(60);
    check_val("d_valid", ev_valid, 1'b1);
    check_val("d_head", {ev_btn, ev_type}, 5'd1);
    check_val("d_ovf_clean", ovf, 1'b0);
    cyc(10);
    check_val("d_head_hold", {ev_btn, ev_type}, 5'd1);
    btn_in[1] = 1'b0; cyc(30);
    btn_in[1] = 1'b1; cyc(30);
    btn_in[1] = 1'b0; cyc(30);
    check_val("d_ovf_set", ovf, 1'b1);
    check_val("d_head_hold2", {ev_btn, ev_type}, 5'd1);
    clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
    check_val("d_ovf_clr", ovf, 1'b0);

    // asynchronous reset with 3 entries queued; no spurious events after
    do_reset();
    ev_ready = 1'b0;
    btn_in = 4'b0111;
    k = 0;
    while (!ev_valid && k < 60) begin
      cyc(1);
      k++;
    end
    check_val("e_fill_timeout", ev_valid, 1'b1);
    cyc(3);
    #1 reset_n = 1'b0;
    #1;
    check_val("e_rst_valid", ev_valid, 1'b0);
    check_val("e_rst_level", level, 4'h0);
    check_val("e_rst_head", {ev_btn, ev_type}, 5'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(10);
    check_val("e_no_spurious", ev_valid, 1'b0);
    ev_ready = 1'b1;
    cyc(40);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int ready_pct;
      ready_pct = ((i / 200) % 3 == 1) ? 10 : 80;
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 24) == 0) btn_in[c] = ~btn_in[c];
      ev_ready = ($urandom_range(0, 99) < ready_pct);
      clr_ovf  = ($urandom_range(0, 40) == 0);
      cyc(1);
    end
    clr_ovf = 1'b0;
    ev_ready = 1'b1;
    cyc(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
